booth_radix4_encoder: RTL and testbench

- Radix-4 modified-Booth recoder for the Goldschmidt divider datapath.
- Converts an 8-bit two's-complement operand `x` into four signed radix-4 digits `sdn1..sdn4`, each in {-2,-1,0,+1,+2}. The downstream multiplier array uses these digits to select partial products.
- Outputs are registered with a one-cycle valid-qualified pipeline stage.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_digit_sel.sv | 23 ++
 rtl/booth_radix4_encoder.sv | 59 +++++
 tb/tb_booth_radix4_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth recoder.
// Digits are 3-bit two's complement values in {-2..+2}.
package booth_pkg;

  typedef logic [2:0] booth_digit_t;

  localparam booth_digit_t BD_P2 = 3'b010;
  localparam booth_digit_t BD_P1 = 3'b001;
  localparam booth_digit_t BD_Z  = 3'b000;
  localparam booth_digit_t BD_M1 = 3'b111;
  localparam booth_digit_t BD_M2 = 3'b110;

  localparam int BOOTH_NDIG = 4;

endpackage

// File: rtl/booth_digit_sel.sv
// Maps one overlapping 3-bit Booth window to its signed digit.
// Purely combinational; 111 and 000 both give a true zero.
module booth_digit_sel
  import booth_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t dig
);

  always_comb begin
    dig = BD_Z;
    unique case (win)
      3'b001,
      3'b010:  dig = BD_P1;
      3'b011:  dig = BD_P2;
      3'b100:  dig = BD_M2;
      3'b101,
      3'b110:  dig = BD_M1;
      default: dig = BD_Z;
    endcase
  end

endmodule

// File: rtl/booth_radix4_encoder.sv
// Radix-4 modified-Booth recoder for an 8-bit operand.
// Optional registered output stage with valid qualification.
module booth_radix4_encoder
  import booth_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   x,
  output logic         out_valid,
  output booth_digit_t sdn1,
  output booth_digit_t sdn2,
  output booth_digit_t sdn3,
  output booth_digit_t sdn4
);

  // x[-1] = 0 appended below the LSB
  logic [8:0]   xe;
  booth_digit_t dig [BOOTH_NDIG];

  assign xe = {x, 1'b0};

  for (genvar i = 0; i < BOOTH_NDIG; i++) begin : g_dig
    booth_digit_sel u_sel (
      .win (xe[2*i+2 -: 3]),
      .dig (dig[i])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        sdn1      <= BD_Z;
        sdn2      <= BD_Z;
        sdn3      <= BD_Z;
        sdn4      <= BD_Z;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sdn1 <= dig[0];
          sdn2 <= dig[1];
          sdn3 <= dig[2];
          sdn4 <= dig[3];
        end
      end
    end
  end else begin : g_comb
    // reset still blanks the outputs in pass-through mode
    assign out_valid = in_valid & ~rst;
    assign sdn1 = rst ? BD_Z : dig[0];
    assign sdn2 = rst ? BD_Z : dig[1];
    assign sdn3 = rst ? BD_Z : dig[2];
    assign sdn4 = rst ? BD_Z : dig[3];
  end

endmodule

// File: tb/tb_booth_radix4_encoder.sv
// Directed bench for the Booth recoder, registered and
// pass-through builds driven from the same stimulus.
module tb_booth_radix4_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] x;

  logic       r_ov, c_ov;
  logic [2:0] r_d1, r_d2, r_d3, r_d4;
  logic [2:0] c_d1, c_d2, c_d3, c_d4;

  int nchk = 0;
  int nerr = 0;

  booth_radix4_encoder #(.REG_OUT(1)) u_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (r_ov),
    .sdn1      (r_d1),
    .sdn2      (r_d2),
    .sdn3      (r_d3),
    .sdn4      (r_d4)
  );

  booth_radix4_encoder #(.REG_OUT(0)) u_comb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (c_ov),
    .sdn1      (c_d1),
    .sdn2      (c_d2),
    .sdn3      (c_d3),
    .sdn4      (c_d4)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rpk();
    return {19'd0, r_ov, r_d4, r_d3, r_d2, r_d1};
  endfunction

  function automatic logic [31:0] cpk();
    return {19'd0, c_ov, c_d4, c_d3, c_d2, c_d1};
  endfunction

  function automatic logic [31:0] pk(
    input logic       v,
    input logic [2:0] d4, d3, d2, d1
  );
    return {19'd0, v, d4, d3, d2, d1};
  endfunction

  function automatic int dsum(
    input logic [2:0] d1, d2, d3, d4
  );
    return int'($signed(d1)) + 4 * int'($signed(d2))
         + 16 * int'($signed(d3)) + 64 * int'($signed(d4));
  endfunction

  function automatic logic ok3(input logic [2:0] d);
    return (d != 3'b011) && (d != 3'b100);
  endfunction

  task automatic step(input logic v, input logic [7:0] xv);
    in_valid = v;
    x        = xv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg", rpk(), 32'd0);
    chk("rst_comb", cpk(), 32'd0);
    rst = 1'b0;

    step(1'b1, 8'd13);
    chk("x13", rpk(),
        pk(1'b1, 3'b000, 3'b001, 3'b111, 3'b001));

    step(1'b1, 8'h7F);
    chk("x7f", rpk(),
        pk(1'b1, 3'b010, 3'b000, 3'b000, 3'b111));
    chk("x7f_comb", cpk(),
        pk(1'b1, 3'b010, 3'b000, 3'b000, 3'b111));

    step(1'b1, 8'h80);
    chk("x80", rpk(),
        pk(1'b1, 3'b110, 3'b000, 3'b000, 3'b000));

    step(1'b1, 8'hFF);
    chk("xff", rpk(),
        pk(1'b1, 3'b000, 3'b000, 3'b000, 3'b111));

    step(1'b1, 8'h00);
    chk("x00", rpk(), 32'h1000);

    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i));
      chk("sweep_v", {31'd0, r_ov}, 32'd1);
      chk("sweep_sum",
          dsum(r_d1, r_d2, r_d3, r_d4),
          int'($signed(8'(i))));
      chk("sweep_code",
          {31'd0, ok3(r_d1) & ok3(r_d2)
                & ok3(r_d3) & ok3(r_d4)},
          32'd1);
      chk("comb_sum",
          dsum(c_d1, c_d2, c_d3, c_d4),
          int'($signed(8'(i))));
    end

    // async reset mid-cycle while valid data is out
    step(1'b1, 8'd13);
    chk("pre_arst", rpk(),
        pk(1'b1, 3'b000, 3'b001, 3'b111, 3'b001));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_now", rpk(), 32'd0);
    chk("arst_comb", cpk(), 32'd0);
    step(1'b1, 8'h7F);
    chk("arst_hold", rpk(), 32'd0);
    #2;
    rst = 1'b0;
    step(1'b1, 8'h7F);
    chk("post_rst", rpk(),
        pk(1'b1, 3'b010, 3'b000, 3'b000, 3'b111));

    step(1'b1, 8'd13);
    in_valid = 1'b0;
    x        = 8'h55;
    #1;
    chk("comb55", cpk(),
        pk(1'b0, 3'b001, 3'b001, 3'b001, 3'b001));
    @(posedge clk);
    #1;
    chk("hold55", rpk(),
        pk(1'b0, 3'b000, 3'b001, 3'b111, 3'b001));
    x = 8'hAA;
    #1;
    chk("combaa", cpk(),
        pk(1'b0, 3'b111, 3'b111, 3'b111, 3'b110));
    @(posedge clk);
    #1;
    chk("holdaa", rpk(),
        pk(1'b0, 3'b000, 3'b001, 3'b111, 3'b001));

    step(1'b1, 8'hFF);
    chk("resume", rpk(),
        pk(1'b1, 3'b000, 3'b000, 3'b000, 3'b111));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
